seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display bank. Accepts a packed 4-bit-per-digit value, decodes each digit to active-low segments (a at bit 6 … g at bit 0), and scans one digit at a time. Includes per-digit decimal points, leading-zero blanking, tear-free double-buffered updates and anti-ghosting dead time. Sits between the datapath and the board display pins, replacing per-digit combinational decoders.

---
 rtl/seg7_scan_driver_if.sv | 25 ++
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Datapath-side port bundle for seg7_scan_driver.
// The master drives the value, decimal points and blanking control; the slave returns the scanned pins and status.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic                  lzb;
  logic [6:0]            seg;
  logic                  seg_dp;
  logic [DIGITS-1:0]     an;
  logic                  busy;
  logic                  frame_tick;

  modport master (
    output load, data, dp, lzb,
    input  seg, seg_dp, an, busy, frame_tick
  );

  modport slave (
    input  load, data, dp, lzb,
    output seg, seg_dp, an, busy, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered digits, leading-zero blanking and dead time.
// Define SEG7_HEX_EN to decode values 10..15 as A,b,C,d,E,F; otherwise those values are blanked.
module seg7_scan_driver #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW = 4 * DIGITS;

  logic [PW-1:0]     pc;
  logic [IW-1:0]     idx;
  logic [DW-1:0]     disp_data;
  logic [DW-1:0]     pend_data;
  logic [DIGITS-1:0] disp_dp;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_v;
  logic              wrap_q;
  logic [6:0]        seg_q;
  logic              seg_dp_q;
  logic [DIGITS-1:0] an_q;
  logic              frame_tick_q;

  logic              tick_c;
  logic              wrap_c;
  logic [DIGITS-1:0] blank_c;
  logic [3:0]        cur_c;
  logic [6:0]        cur_seg_c;

  // Active-low a..g (a at bit 6).
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
`ifdef SEG7_HEX_EN
      4'd10:   decode = 7'b0001000;
      4'd11:   decode = 7'b1100000;
      4'd12:   decode = 7'b0110001;
      4'd13:   decode = 7'b1000010;
      4'd14:   decode = 7'b0110000;
      4'd15:   decode = 7'b0111000;
`endif
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    tick_c = (pc == PW'(DIV - 1));
    wrap_c = tick_c && (idx == IW'(DIGITS - 1));
  end

  // Blank zeros from the most significant digit down until the first non-zero; digit 0 always shows.
  always_comb begin
    logic run;
    run     = bus.lzb;
    blank_c = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run        = run && (disp_data[4*i +: 4] == 4'd0);
      blank_c[i] = run;
    end
  end

  always_comb begin
    cur_c     = disp_data[4*idx +: 4];
    cur_seg_c = blank_c[idx] ? 7'b1111111 : decode(cur_c);
  end

  // Scan counters, double buffer and registered pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      idx          <= '0;
      disp_data    <= '0;
      disp_dp      <= '0;
      pend_data    <= '0;
      pend_dp      <= '0;
      pend_v       <= 1'b0;
      wrap_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= 7'b1111111;
      seg_dp_q     <= 1'b1;
      an_q         <= '1;
    end else begin
      pc <= tick_c ? '0 : pc + PW'(1);
      if (tick_c) begin
        idx <= wrap_c ? '0 : idx + IW'(1);
      end

      // A load landing on the frame boundary bypasses the pending buffer.
      if (wrap_c) begin
        if (bus.load) begin
          disp_data <= bus.data;
          disp_dp   <= bus.dp;
        end else if (pend_v) begin
          disp_data <= pend_data;
          disp_dp   <= pend_dp;
        end
        pend_v <= 1'b0;
      end else if (bus.load) begin
        pend_data <= bus.data;
        pend_dp   <= bus.dp;
        pend_v    <= 1'b1;
      end

      // Two stages so the pulse lines up with the first digit-0 output of the frame.
      wrap_q       <= wrap_c;
      frame_tick_q <= wrap_q;

      if (tick_c) begin
        an_q     <= '1;
        seg_q    <= 7'b1111111;
        seg_dp_q <= 1'b1;
      end else begin
        an_q     <= ~(DIGITS'(1) << idx);
        seg_q    <= cur_seg_c;
        seg_dp_q <= ~disp_dp[idx];
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.seg_dp     = seg_dp_q;
  assign bus.an         = an_q;
  assign bus.busy       = pend_v;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, DIV=4 (16-cycle frame).
module tb_seg7_scan_driver;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] obs_seg [16];
  logic [3:0] obs_an  [16];
  logic       obs_dp  [16];
  logic       obs_ft  [16];
  logic [6:0] es      [4];

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    bus.data = d;
    bus.dp   = p;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  // Records one full frame starting at the current sample point.
  task automatic frame_scan();
    for (int j = 0; j < 16; j++) begin
      obs_seg[j] = bus.seg;
      obs_an[j]  = bus.an;
      obs_dp[j]  = bus.seg_dp;
      obs_ft[j]  = bus.frame_tick;
      step(1);
    end
  endtask

  // Expected anode pattern j cycles after a frame's first digit-0 output.
  function automatic logic [3:0] an_exp(input int j);
    int k;
    k = j % 16;
    if (k % 4 == 3) return 4'hF;
    return ~(4'b0001 << (k / 4));
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.load = 1'b0;
    bus.data = '0;
    bus.dp   = '0;
    bus.lzb  = 1'b0;
    step(2);
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b exp 1111111", bus.seg); end
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", bus.an); end
    checks++; if (bus.seg_dp !== 1'b1) begin errors++; $display("FAIL reset_seg_dp got %b exp 1", bus.seg_dp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b exp 0", bus.frame_tick); end
    rst_n = 1'b1;
    step(1);
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL first_an got %b exp 1110", bus.an); end
    checks++; if (bus.seg !== 7'b0000001) begin errors++; $display("FAIL first_seg got %b exp 0000001", bus.seg); end
    checks++; if (bus.seg_dp !== 1'b1) begin errors++; $display("FAIL first_seg_dp got %b exp 1", bus.seg_dp); end
    for (int k = 2; k <= 17; k++) begin
      step(1);
      checks++;
      if (bus.frame_tick !== (k == 17)) begin
        errors++; $display("FAIL reset_ft edge=%0d got %b exp %b", k, bus.frame_tick, (k == 17));
      end
      checks++;
      if (bus.an !== an_exp(k - 1)) begin
        errors++; $display("FAIL reset_scan_an edge=%0d got %b exp %b", k, bus.an, an_exp(k - 1));
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg;
    logic       exp_dp;
    pulse_load(16'h1234, 4'b0100);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL scan_busy_rise got %b exp 1", bus.busy); end
    checks++; if (bus.seg !== 7'b0000001) begin errors++; $display("FAIL scan_old_seg got %b exp 0000001", bus.seg); end
    step(14);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL scan_busy_fall got %b exp 0", bus.busy); end
    step(1);
    frame_scan();
    es[0] = 7'b1001100; es[1] = 7'b0000110; es[2] = 7'b0010010; es[3] = 7'b1001111;
    for (int j = 0; j < 16; j++) begin
      exp_seg = (j % 4 == 3) ? 7'b1111111 : es[j / 4];
      exp_dp  = (j % 4 != 3 && j / 4 == 2) ? 1'b0 : 1'b1;
      checks++; if (obs_an[j] !== an_exp(j)) begin errors++; $display("FAIL scan_an j=%0d got %b exp %b", j, obs_an[j], an_exp(j)); end
      checks++; if (obs_seg[j] !== exp_seg) begin errors++; $display("FAIL scan_seg j=%0d got %b exp %b", j, obs_seg[j], exp_seg); end
      checks++; if (obs_dp[j] !== exp_dp) begin errors++; $display("FAIL scan_dp j=%0d got %b exp %b", j, obs_dp[j], exp_dp); end
      checks++; if (obs_ft[j] !== (j == 0)) begin errors++; $display("FAIL scan_ft j=%0d got %b exp %b", j, obs_ft[j], (j == 0)); end
    end
  endtask

  task automatic test_double_buffer();
    pulse_load(16'h1111, 4'b0000);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL db_busy1 got %b exp 1", bus.busy); end
    pulse_load(16'h2222, 4'b0000);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL db_busy2 got %b exp 1", bus.busy); end
    checks++; if (bus.seg !== 7'b1001100) begin errors++; $display("FAIL db_hold_d0 got %b exp 1001100", bus.seg); end
    step(12);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL db_busy_late got %b exp 1", bus.busy); end
    checks++; if (bus.seg !== 7'b1001111) begin errors++; $display("FAIL db_hold_d3 got %b exp 1001111", bus.seg); end
    step(1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL db_busy_fall got %b exp 0", bus.busy); end
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL db_dead got %b exp 1111111", bus.seg); end
    step(1);
    checks++; if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL db_ft got %b exp 1", bus.frame_tick); end
    checks++; if (bus.seg !== 7'b0010010) begin errors++; $display("FAIL db_new_d0 got %b exp 0010010", bus.seg); end
    step(4);
    checks++; if (bus.seg !== 7'b0010010) begin errors++; $display("FAIL db_new_d1 got %b exp 0010010", bus.seg); end
    step(10);
    pulse_load(16'h5678, 4'b0001);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bnd_busy got %b exp 0", bus.busy); end
    step(1);
    checks++; if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL bnd_ft got %b exp 1", bus.frame_tick); end
    checks++; if (bus.seg !== 7'b0000000) begin errors++; $display("FAIL bnd_seg got %b exp 0000000", bus.seg); end
    checks++; if (bus.seg_dp !== 1'b0) begin errors++; $display("FAIL bnd_dp got %b exp 0", bus.seg_dp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bnd_busy2 got %b exp 0", bus.busy); end
  endtask

  task automatic test_lzb();
    logic [6:0] exp_seg;
    bus.lzb = 1'b1;
    pulse_load(16'h0070, 4'b0000);
    step(15);
    frame_scan();
    es[0] = 7'b0000001; es[1] = 7'b0001111; es[2] = 7'b1111111; es[3] = 7'b1111111;
    for (int j = 0; j < 16; j++) begin
      exp_seg = (j % 4 == 3) ? 7'b1111111 : es[j / 4];
      checks++; if (obs_an[j] !== an_exp(j)) begin errors++; $display("FAIL lzb70_an j=%0d got %b exp %b", j, obs_an[j], an_exp(j)); end
      checks++; if (obs_seg[j] !== exp_seg) begin errors++; $display("FAIL lzb70_seg j=%0d got %b exp %b", j, obs_seg[j], exp_seg); end
    end
    pulse_load(16'h0000, 4'b0000);
    step(15);
    frame_scan();
    es[0] = 7'b0000001; es[1] = 7'b1111111;
    for (int j = 0; j < 16; j++) begin
      exp_seg = (j % 4 == 3) ? 7'b1111111 : ((j / 4 == 0) ? es[0] : es[1]);
      checks++; if (obs_seg[j] !== exp_seg) begin errors++; $display("FAIL lzb0_seg j=%0d got %b exp %b", j, obs_seg[j], exp_seg); end
    end
    bus.lzb = 1'b0;
    step(12);
    checks++; if (bus.seg !== 7'b0000001) begin errors++; $display("FAIL lzb_off_d3 got %b exp 0000001", bus.seg); end
    step(4);
  endtask

  task automatic test_hex();
    logic [6:0] exp_seg;
    pulse_load(16'hABCF, 4'b0000);
    step(15);
    frame_scan();
`ifdef SEG7_HEX_EN
    es[0] = 7'b0111000; es[1] = 7'b0110001; es[2] = 7'b1100000; es[3] = 7'b0001000;
`else
    es[0] = 7'b1111111; es[1] = 7'b1111111; es[2] = 7'b1111111; es[3] = 7'b1111111;
`endif
    for (int j = 0; j < 16; j++) begin
      exp_seg = (j % 4 == 3) ? 7'b1111111 : es[j / 4];
      checks++; if (obs_seg[j] !== exp_seg) begin errors++; $display("FAIL hex_seg j=%0d got %b exp %b", j, obs_seg[j], exp_seg); end
    end
    bus.lzb = 1'b1;
    pulse_load(16'h0A00, 4'b0000);
    step(15);
    frame_scan();
    es[0] = 7'b0000001; es[1] = 7'b0000001; es[3] = 7'b1111111;
`ifdef SEG7_HEX_EN
    es[2] = 7'b0001000;
`else
    es[2] = 7'b1111111;
`endif
    for (int j = 0; j < 16; j++) begin
      exp_seg = (j % 4 == 3) ? 7'b1111111 : es[j / 4];
      checks++; if (obs_seg[j] !== exp_seg) begin errors++; $display("FAIL hex_lzb_seg j=%0d got %b exp %b", j, obs_seg[j], exp_seg); end
    end
    bus.lzb = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp_seg;
    pulse_load(16'h9999, 4'b1111);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre got %b exp 1", bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL rm_seg got %b exp 1111111", bus.seg); end
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL rm_an got %b exp 1111", bus.an); end
    checks++; if (bus.seg_dp !== 1'b1) begin errors++; $display("FAIL rm_seg_dp got %b exp 1", bus.seg_dp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus.busy); end
    step(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      exp_seg = ((k - 1) % 4 == 3) ? 7'b1111111 : 7'b0000001;
      checks++; if (bus.seg !== exp_seg) begin errors++; $display("FAIL rm_seg_after edge=%0d got %b exp %b", k, bus.seg, exp_seg); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy_after got %b exp 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_double_buffer();
    test_lzb();
    test_hex();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
